// File: rtl/hack_data_mem_if.sv
// Hack data-memory bus: CPU data access, keyboard scan code, and framebuffer video read port.
// Master is the CPU/video side; slave is the memory responder.
interface hack_data_mem_if;
  logic [14:0] addressM;
  logic        writeM;
  logic [15:0] outM;
  logic [15:0] inM;
  logic [15:0] key_code;
  logic        vid_req;
  logic [12:0] vid_addr;
  logic        vid_ack;
  logic [15:0] vid_data;

  modport master (
    output addressM, writeM, outM, key_code, vid_req, vid_addr,
    input  inM, vid_ack, vid_data
  );

  modport slave (
    input  addressM, writeM, outM, key_code, vid_req, vid_addr,
    output inM, vid_ack, vid_data
  );
endinterface

// File: rtl/hack_data_mem.sv
// Hack data memory: RAM/SCREEN/KBD decode, zero-latency CPU read, video read port (ack 1 cycle after accept, CPU screen writes stall it).
// Optional macro HACK_MEM_BOUNDS_FAULT_EN adds a sticky mem_fault output for illegal accesses.
module hack_data_mem #(
  parameter int unsigned RAM_WORDS    = 16384,
  parameter logic [14:0] SCREEN_BASE  = 15'h4000,
  parameter int unsigned SCREEN_WORDS = 8192,
  parameter logic [14:0] KBD_ADDR     = 15'h6000
) (
  input  logic clk,
  input  logic reset,
`ifdef HACK_MEM_BOUNDS_FAULT_EN
  output logic mem_fault,
`endif
  hack_data_mem_if.slave bus
);
  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCR_AW = $clog2(SCREEN_WORDS);

  typedef enum logic {ST_IDLE, ST_ACK} vid_state_t;

  logic [15:0] r_ram [RAM_WORDS];
  logic [15:0] r_scr [SCREEN_WORDS];
  logic [15:0] r_kbd;
  logic [15:0] r_vid_data;
  logic        r_vid_ack;
  vid_state_t  r_state;

  logic              w_is_ram;
  logic              w_is_scr;
  logic              w_is_kbd;
  logic              w_unmapped;
  logic [RAM_AW-1:0] w_ram_idx;
  logic [SCR_AW-1:0] w_scr_idx;
  logic              w_cpu_scr_wr;

  assign w_is_ram   = 32'(bus.addressM) < RAM_WORDS;
  assign w_is_scr   = (32'(bus.addressM) >= 32'(SCREEN_BASE)) &&
                      (32'(bus.addressM) <  32'(SCREEN_BASE) + SCREEN_WORDS);
  assign w_is_kbd   = bus.addressM == KBD_ADDR;
  assign w_unmapped = !(w_is_ram || w_is_scr || w_is_kbd);

  // Screen offset is forced to 0 outside SCR so it can never alias into other regions.
  assign w_ram_idx    = RAM_AW'(bus.addressM);
  assign w_scr_idx    = w_is_scr ? SCR_AW'(bus.addressM - SCREEN_BASE) : '0;
  assign w_cpu_scr_wr = bus.writeM && w_is_scr;

  always_comb begin
    bus.inM = 16'h0000;
    if (w_is_ram)      bus.inM = r_ram[w_ram_idx];
    else if (w_is_scr) bus.inM = r_scr[w_scr_idx];
    else if (w_is_kbd) bus.inM = r_kbd;
  end

  always_ff @(posedge clk) begin
    if (bus.writeM && w_is_ram) r_ram[w_ram_idx] <= bus.outM;
    if (w_cpu_scr_wr)           r_scr[w_scr_idx] <= bus.outM;
  end

  always_ff @(posedge clk) begin
    if (reset) r_kbd <= 16'h0000;
    else       r_kbd <= bus.key_code;
  end

  // Video port: ACK lasts one cycle, so back-to-back requests get at most one ack per two cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_vid_ack  <= 1'b0;
      r_vid_data <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_vid_ack <= 1'b0;
          if (bus.vid_req && !w_cpu_scr_wr) begin
            r_vid_data <= (32'(bus.vid_addr) < SCREEN_WORDS) ?
                          r_scr[SCR_AW'(bus.vid_addr)] : 16'h0000;
            r_vid_ack  <= 1'b1;
            r_state    <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_vid_ack <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_vid_ack <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.vid_ack  = r_vid_ack;
  assign bus.vid_data = r_vid_data;

`ifdef HACK_MEM_BOUNDS_FAULT_EN
  logic r_mem_fault;

  always_ff @(posedge clk) begin
    if (reset)                                    r_mem_fault <= 1'b0;
    else if (w_unmapped || (bus.writeM && w_is_kbd)) r_mem_fault <= 1'b1;
  end

  assign mem_fault = r_mem_fault;
`endif
endmodule

// File: tb/tb_hack_data_mem.sv
// Directed bench for hack_data_mem: inputs change 1 time unit after each rising edge, outputs checked there too.
module tb_hack_data_mem;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  hack_data_mem_if bus ();

`ifdef HACK_MEM_BOUNDS_FAULT_EN
  logic mem_fault;
  hack_data_mem dut (.clk(clk), .reset(reset), .mem_fault(mem_fault), .bus(bus.slave));
`else
  hack_data_mem dut (.clk(clk), .reset(reset), .bus(bus.slave));
`endif

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cpu(input logic [14:0] a, input logic w, input logic [15:0] d);
    bus.addressM = a;
    bus.writeM   = w;
    bus.outM     = d;
  endtask

  task automatic rd(input string tag, input logic [14:0] a, input logic [15:0] exp);
    cpu(a, 1'b0, 16'h0000);
    #1;
    chk(tag, bus.inM, exp);
  endtask

  initial begin
    reset = 1'b1;
    cpu(15'h0000, 1'b0, 16'h0000);
    bus.key_code = 16'h5555;
    bus.vid_req  = 1'b0;
    bus.vid_addr = 13'h0000;
    tick();
    tick();
    bus.key_code = 16'h0000;
    chk("rst_vid_ack", {15'h0, bus.vid_ack}, 16'h0000);
    chk("rst_vid_data", bus.vid_data, 16'h0000);
    rd("rst_kbd", 15'h6000, 16'h0000);
`ifdef HACK_MEM_BOUNDS_FAULT_EN
    chk("rst_fault", {15'h0, mem_fault}, 16'h0000);
`endif
    reset = 1'b0;

    // Seed words used later to detect stray writes/aliasing.
    cpu(15'h0011, 1'b1, 16'h0BAD); tick();
    cpu(15'h2001, 1'b1, 16'h3333); tick();
    cpu(15'h4001, 1'b1, 16'h7777); tick();
    cpu(15'h4007, 1'b1, 16'h0000); tick();

    cpu(15'h0010, 1'b1, 16'h1234); tick();
    rd("raw_0010", 15'h0010, 16'h1234);
    rd("neighbor_0011", 15'h0011, 16'h0BAD);

    cpu(15'h0010, 1'b1, 16'h5678);
    #1;
    chk("no_bypass", bus.inM, 16'h1234);
    tick();
    rd("raw2_0010", 15'h0010, 16'h5678);

    cpu(15'h4005, 1'b1, 16'hFFFF); tick();
    rd("scr_rd_4005", 15'h4005, 16'hFFFF);
    bus.vid_req = 1'b1; bus.vid_addr = 13'd5; tick();
    chk("vid5_ack", {15'h0, bus.vid_ack}, 16'h0001);
    chk("vid5_data", bus.vid_data, 16'hFFFF);
    bus.vid_req = 1'b0; tick();
    chk("vid5_ack_drop", {15'h0, bus.vid_ack}, 16'h0000);
    chk("vid5_data_hold", bus.vid_data, 16'hFFFF);

    // Collision: CPU writes the same framebuffer word in the request cycle.
    cpu(15'h4007, 1'b1, 16'hA5A5);
    bus.vid_req = 1'b1; bus.vid_addr = 13'd7; tick();
    chk("coll_stall", {15'h0, bus.vid_ack}, 16'h0000);
    cpu(15'h4007, 1'b0, 16'h0000); tick();
    chk("coll_ack", {15'h0, bus.vid_ack}, 16'h0001);
    chk("coll_data", bus.vid_data, 16'hA5A5);
    bus.vid_req = 1'b0; tick();
    chk("coll_ack_drop", {15'h0, bus.vid_ack}, 16'h0000);

    // Held request: acks on alternate cycles only.
    bus.vid_req = 1'b1; bus.vid_addr = 13'd5; tick();
    chk("b2b_ack0", {15'h0, bus.vid_ack}, 16'h0001);
    tick();
    chk("b2b_gap", {15'h0, bus.vid_ack}, 16'h0000);
    tick();
    chk("b2b_ack1", {15'h0, bus.vid_ack}, 16'h0001);
    bus.vid_req = 1'b0; tick();
    chk("b2b_idle", {15'h0, bus.vid_ack}, 16'h0000);

    bus.key_code = 16'h0084;
    rd("kbd_latency", 15'h6000, 16'h0000);
    tick();
    rd("kbd_val", 15'h6000, 16'h0084);
    cpu(15'h6000, 1'b1, 16'h1111); tick();
    rd("kbd_not_writable", 15'h6000, 16'h0084);
`ifdef HACK_MEM_BOUNDS_FAULT_EN
    chk("kbd_wr_fault", {15'h0, mem_fault}, 16'h0001);
`endif

    cpu(15'h6001, 1'b1, 16'hBEEF);
    #1;
    chk("unmap_rd_pre", bus.inM, 16'h0000);
    tick();
    rd("unmap_rd", 15'h6001, 16'h0000);
    rd("unmap_ram_0010", 15'h0010, 16'h5678);
    rd("unmap_ram_2001", 15'h2001, 16'h3333);
    rd("unmap_scr_4001", 15'h4001, 16'h7777);
    rd("unmap_scr_4005", 15'h4005, 16'hFFFF);
    rd("unmap_7fff", 15'h7FFF, 16'h0000);
    tick();
`ifdef HACK_MEM_BOUNDS_FAULT_EN
    chk("fault_sticky", {15'h0, mem_fault}, 16'h0001);
`endif

    // Reset while the video port is in ACK.
    rd("pre_rst_scr", 15'h4005, 16'hFFFF);
    bus.vid_req = 1'b1; bus.vid_addr = 13'd5; tick();
    chk("pre_rst_ack", {15'h0, bus.vid_ack}, 16'h0001);
    reset = 1'b1; tick();
    chk("rst_ack_clear", {15'h0, bus.vid_ack}, 16'h0000);
    rd("rst_kbd_clear", 15'h6000, 16'h0000);
    chk("rst_data_clear", bus.vid_data, 16'h0000);
    reset = 1'b0; bus.vid_req = 1'b0; tick();
    chk("post_rst_no_ack", {15'h0, bus.vid_ack}, 16'h0000);
    rd("post_rst_ram", 15'h0010, 16'h5678);
`ifdef HACK_MEM_BOUNDS_FAULT_EN
    chk("post_rst_fault", {15'h0, mem_fault}, 16'h0000);
`endif
    tick();
    rd("post_rst_kbd", 15'h6000, 16'h0084);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
